// File: rtl/fmul_share_arb.sv
// Round-robin arbiter that shares one pipelined fmul among NUM_REQ requesters and routes results back by owner tag.
// Optional per-requester grant and conflict counters are built when FMUL_SHARE_ARB_STATS_EN is defined.
module fmul_share_arb #(
  parameter int NUM_REQ = 2,
  parameter int LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_x1,
  input  logic [32*NUM_REQ-1:0]   req_x2,
  output logic                    fmul_stage1_valid,
  output logic [31:0]             fmul_x1,
  output logic [31:0]             fmul_x2,
  input  logic [31:0]             fmul_y,
  input  logic                    fmul_ovf,
  input  logic                    fmul_unf,
  input  logic                    fmul_valid,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [31:0]             resp_y,
  output logic                    resp_ovf,
  output logic                    resp_unf,
  output logic                    err
`ifdef FMUL_SHARE_ARB_STATS_EN
  ,
  output logic [32*NUM_REQ-1:0]   stat_grants,
  output logic [31:0]             stat_conflicts
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(LATENCY + 1);

  // Handshake contract: a requester raises req_valid with stable operands and
  // holds both until req_valid & req_ready is seen high at a rising clk edge.
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant_idx;
  logic          grant_any;
  logic          hs;
  logic [IW-1:0] owner_q;

  logic [LATENCY-1:0] tag_v;
  logic [IW-1:0]      tag_o [LATENCY];
  logic [WW-1:0]      warm;
  logic               chk_en;

  always_comb begin : arb_search
    int idx;
    idx       = 0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = IW'(idx);
      end
    end
  end

  assign hs = grant_any & ~rst;

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr            <= '0;
      fmul_stage1_valid <= 1'b0;
      fmul_x1           <= '0;
      fmul_x2           <= '0;
      owner_q           <= '0;
    end else begin
      fmul_stage1_valid <= hs;
      if (hs) begin
        rr_ptr  <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        fmul_x1 <= req_x1[32*grant_idx +: 32];
        fmul_x2 <= req_x2[32*grant_idx +: 32];
        owner_q <= grant_idx;
      end
    end
  end

  // Stage 0 lines up with the fmul's first internal register, so the last stage
  // is valid in exactly the cycle fmul_valid should be.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      for (int i = 0; i < LATENCY; i++) tag_o[i] <= '0;
    end else begin
      tag_v[0] <= fmul_stage1_valid;
      tag_o[0] <= owner_q;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_o[i] <= tag_o[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= '0;
      resp_y     <= '0;
      resp_ovf   <= 1'b0;
      resp_unf   <= 1'b0;
    end else begin
      resp_valid <= '0;
      if (tag_v[LATENCY-1]) begin
        resp_valid <= NUM_REQ'(1) << tag_o[LATENCY-1];
        resp_y     <= fmul_y;
        resp_ovf   <= fmul_ovf;
        resp_unf   <= fmul_unf;
      end
    end
  end

  // The fmul keeps stale contents across our reset; ignore its valid until it has flushed.
  assign chk_en = (warm == WW'(LATENCY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm <= '0;
      err  <= 1'b0;
    end else begin
      if (!chk_en) warm <= warm + 1'b1;
      if (chk_en && (fmul_valid != tag_v[LATENCY-1])) err <= 1'b1;
    end
  end

`ifdef FMUL_SHARE_ARB_STATS_EN
  logic [31:0] grant_cnt [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
      stat_conflicts <= '0;
    end else begin
      if (hs) grant_cnt[grant_idx] <= grant_cnt[grant_idx] + 32'd1;
      if ($countones(req_valid) >= 2) stat_conflicts <= stat_conflicts + 32'd1;
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_grants[32*i +: 32] = grant_cnt[i];
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/fmul_share_arb.md
Name: fmul_share_arb

Overview:
- Round-robin arbiter sharing one pipelined fmul among NUM_REQ requesters. The fmul has 3 register stages, a valid passthrough, no stall and no reset.
- Per cycle: accepts at most one operand pair, issues it to the fmul, and tracks the owner with an internal tag pipeline.
- Routes each result back with a one-hot response valid.
- Sits between the FPU dispatch ports and the single fmul instance.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
LATENCY, 3, fmul register stages from input to output (valid in to valid out)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
req_x1  input  32*NUM_REQ  operand 1, requester i at [32*i+31:32*i]
req_x2  input  32*NUM_REQ  operand 2, same packing
fmul_stage1_valid  output  1  valid into fmul
fmul_x1  output  32  operand 1 into fmul
fmul_x2  output  32  operand 2 into fmul
fmul_y  input  32  fmul result
fmul_ovf  input  1  fmul overflow flag
fmul_unf  input  1  fmul underflow flag
fmul_valid  input  1  fmul output valid
resp_valid  output  NUM_REQ  one-hot result valid
resp_y  output  32  result, shared by all requesters
resp_ovf  output  1  overflow of delivered result
resp_unf  output  1  underflow of delivered result
err  output  1  sticky protocol error

Behaviour:
- Arbitration:
  - Combinational round-robin search over req_valid, starting at pointer rr_ptr.
  - req_ready[g] = 1 for the winner g only; zero when no req_valid.
  - Handshake = req_valid[i] & req_ready[i]; at most one per cycle.
  - Requester holds req_valid and operands stable until its handshake.
- Pointer: on handshake, rr_ptr <= (g+1) mod NUM_REQ; otherwise unchanged. A continuously asserting requester cannot starve others.
- Issue register: on each posedge, fmul_stage1_valid <= handshake, fmul_x1/fmul_x2 <= winner operands. Operands hold the previous value when there is no handshake.
- Throughput: 1 accept per cycle, no bubbles.
- Tag pipeline:
  - Shift register of depth LATENCY holding {valid, owner index}.
  - Stage 0 loads {fmul_stage1_valid, issued owner} each cycle, aligned with fmul_valid.
  - Shifts every cycle unconditionally; no backpressure anywhere.
- Response register:
  - On each posedge, resp_valid <= onehot(owner) if the tag at depth LATENCY is valid, else 0.
  - resp_y/resp_ovf/resp_unf <= fmul_y/fmul_ovf/fmul_unf when the tag is valid, else hold.
- Latency: handshake in cycle 0 -> fmul_stage1_valid cycle 1 -> fmul_valid cycle 1+LATENCY -> resp_valid cycle LATENCY+2 (5 by default). Exactly one resp_valid cycle per accept; the response cannot be refused.
- Ordering: responses return in accept order.
- Error check:
  - err sets when fmul_valid differs from the tag valid at depth LATENCY.
  - Check is masked until LATENCY cycles after reset release (warm-up counter).
  - err clears only on rst.
- Reset (asynchronous, any time): clears rr_ptr=0, fmul_stage1_valid=0, fmul_x1=fmul_x2=0, all tags invalid, resp_valid=0, resp_y=0, resp_ovf=resp_unf=0, err=0, warm-up counter=0.
  - In-flight operations are dropped; their fmul outputs are never delivered, since the fmul itself is not reset.
  - req_ready is combinational and 0 while rst is high.
- Simultaneous events: accept and response to the same requester in one cycle are independent and both allowed.

Optional Feature:
- Macro FMUL_SHARE_ARB_STATS_EN.
- Defined: adds output stat_grants (32*NUM_REQ) with one 32-bit wrap-around counter per requester.
  - Counter increments on that requester's handshake.
  - Counter also increments in a cycle where it competed (req_valid high, not granted)? No: only handshakes count.
  - Adds output stat_conflicts (32): counts cycles with 2 or more req_valid bits set.
  - All counters reset to 0 on rst; 0xFFFFFFFF wraps to 0.
- Undefined: ports, counters and logic are absent; all other behaviour is identical.

Test Plan:
- Single request: req 0 with x1=0x40000000, x2=0x40400000 -> req_ready[0] cycle 0, resp_valid=01 cycle 5, resp_y=0x40C00000, ovf=unf=0.
- Both requesters continuously valid, NUM_REQ=2 -> grants alternate 0,1,0,1; one fmul_stage1_valid per cycle; responses alternate 01/10 in accept order, 5 cycles after each accept.
- NUM_REQ=4 with requesters 1 and 3 only, rr_ptr=2 -> first grant 3, then 1, then 3; requesters 0 and 2 never get ready.
- rst pulsed 2 cycles after 3 back-to-back accepts -> no resp_valid afterwards; err stays 0 despite stale fmul_valid during warm-up; the next accept responds normally.
- fmul_valid forced high with no request, after warm-up -> err=1 the next cycle and stays 1 until rst.
- FMUL_SHARE_ARB_STATS_EN defined, 10 cycles both valid then 4 cycles req 0 only -> stat_grants = {5 (req 1), 9 (req 0)}, stat_conflicts = 10.
